// File: rtl/body_rate_controller_pkg.sv
// Shared constants, FSM state type and product scaling helper for the body-rate controller.
package body_rate_controller_pkg;

  localparam int RATE_BIT_WIDTH    = 16;
  localparam int FIXED_POINT_SHIFT = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [15:0] ALL_ZERO_2BYTE = 16'h0000;

  localparam logic [1:0] AXIS_YAW   = 2'd0;
  localparam logic [1:0] AXIS_PITCH = 2'd1;
  localparam logic [1:0] AXIS_ROLL  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_ERR      = 3'd2,
    ST_MAC      = 3'd3,
    ST_SAT      = 3'd4,
    ST_COMPLETE = 3'd5
  } state_e;

  // Sign-extend a 32-bit product to accumulator width, then scale it down.
  function automatic logic signed [33:0] shift_product(input logic signed [31:0] p, input int sh);
    logic signed [33:0] ext;
    ext = {{2{p[31]}}, p};
    return ext >>> sh;
  endfunction

endpackage

// File: rtl/body_rate_controller_signed_saturate.sv
// Symmetric signed clamp of an arbitrary-width value into a 16-bit result.
module signed_saturate #(
  parameter int IN_W  = 17,
  parameter int LIMIT = 32767
) (
  input  logic signed [IN_W-1:0] in_i,
  output logic signed [15:0]     out_o
);

  localparam logic signed [IN_W-1:0] HI = IN_W'(LIMIT);
  localparam logic signed [IN_W-1:0] LO = IN_W'(-LIMIT);

  // Clamp to [-LIMIT, +LIMIT]; in-range values pass through truncated to 16 bits.
  always_comb begin
    if (in_i > HI) begin
      out_o = 16'(HI);
    end else if (in_i < LO) begin
      out_o = 16'(LO);
    end else begin
      out_o = in_i[15:0];
    end
  end

endmodule

// File: rtl/body_rate_controller.sv
// Inner-loop PI(D) body-rate controller: three axes time-share one MAC datapath.
// The derivative term and its prev-error registers exist only when DERIVATIVE_TERM_EN is defined.
module body_rate_controller
  import body_rate_controller_pkg::*;
#(
  parameter int PR_KP        = 16,
  parameter int PR_KI        = 1,
  parameter int YAW_KP       = 24,
  parameter int YAW_KI       = 0,
`ifdef DERIVATIVE_TERM_EN
  parameter int KD           = 8,
`endif
  parameter int GAIN_SHIFT   = FIXED_POINT_SHIFT,
  parameter int INT_LIMIT    = 4000,
  parameter int OUT_LIMIT    = 1600,
  parameter int THROTTLE_MAX = 4000,
  parameter int THROTTLE_ARM = 160
) (
  input  logic                              us_clk,
  input  logic                              resetn,
  input  logic                              start_signal,
  input  logic signed [RATE_BIT_WIDTH-1:0]  throttle_rate_in,
  input  logic signed [RATE_BIT_WIDTH-1:0]  yaw_rate_target,
  input  logic signed [RATE_BIT_WIDTH-1:0]  pitch_rate_target,
  input  logic signed [RATE_BIT_WIDTH-1:0]  roll_rate_target,
  input  logic signed [RATE_BIT_WIDTH-1:0]  yaw_rate_actual,
  input  logic signed [RATE_BIT_WIDTH-1:0]  pitch_rate_actual,
  input  logic signed [RATE_BIT_WIDTH-1:0]  roll_rate_actual,
  output logic signed [RATE_BIT_WIDTH-1:0]  throttle_out,
  output logic signed [RATE_BIT_WIDTH-1:0]  yaw_out,
  output logic signed [RATE_BIT_WIDTH-1:0]  pitch_out,
  output logic signed [RATE_BIT_WIDTH-1:0]  roll_out,
  output logic                              active_signal,
  output logic                              complete_signal
);

  localparam int W = RATE_BIT_WIDTH;

  state_e                state_q;
  logic [1:0]            axis_q;
  logic signed [W-1:0]   thr_q;
  logic signed [W-1:0]   tgt_q      [0:2];
  logic signed [W-1:0]   act_q      [0:2];
  logic signed [W-1:0]   integ_q    [0:2];
  logic signed [W-1:0]   out_q      [0:2];
  logic signed [W-1:0]   err_q;
  logic signed [33:0]    acc_q;
  logic signed [W-1:0]   throttle_q;
  logic                  active_q;
  logic                  complete_q;

  logic signed [W-1:0]   tgt_s;
  logic signed [W-1:0]   act_s;
  logic signed [W-1:0]   integ_cur_s;
  logic signed [W-1:0]   kp_s;
  logic signed [W-1:0]   ki_s;
  logic signed [W:0]     err_raw_s;
  logic signed [W-1:0]   err_d;
  logic signed [W:0]     integ_sum_s;
  logic signed [W-1:0]   integ_d;
  logic signed [W-1:0]   out_d;
  logic signed [W-1:0]   throttle_d;
  logic                  arm_s;
  logic signed [31:0]    prod_p_s;
  logic signed [31:0]    prod_i_s;
  logic signed [33:0]    d_term_s;
  logic signed [33:0]    acc_d;

  // Select the operands of the axis currently owning the shared datapath.
  always_comb begin
    tgt_s       = tgt_q[axis_q];
    act_s       = act_q[axis_q];
    integ_cur_s = integ_q[axis_q];
    if (axis_q == AXIS_YAW) begin
      kp_s = 16'(YAW_KP);
      ki_s = 16'(YAW_KI);
    end else begin
      kp_s = 16'(PR_KP);
      ki_s = 16'(PR_KI);
    end
  end

  assign err_raw_s   = {tgt_s[W-1], tgt_s} - {act_s[W-1], act_s};
  assign integ_sum_s = {integ_cur_s[W-1], integ_cur_s} + {err_d[W-1], err_d};
  assign arm_s       = (thr_q >= 16'(THROTTLE_ARM));

  signed_saturate #(.IN_W(W + 1), .LIMIT(32767)) u_err_sat (
    .in_i  (err_raw_s),
    .out_o (err_d)
  );

  signed_saturate #(.IN_W(W + 1), .LIMIT(INT_LIMIT)) u_integ_sat (
    .in_i  (integ_sum_s),
    .out_o (integ_d)
  );

  signed_saturate #(.IN_W(34), .LIMIT(OUT_LIMIT)) u_out_sat (
    .in_i  (acc_q),
    .out_o (out_d)
  );

  // Throttle is one-sided: negative demand means motors idle.
  always_comb begin
    if (throttle_rate_in < 16'sd0) begin
      throttle_d = 16'sd0;
    end else if (throttle_rate_in > 16'(THROTTLE_MAX)) begin
      throttle_d = 16'(THROTTLE_MAX);
    end else begin
      throttle_d = throttle_rate_in;
    end
  end

  assign prod_p_s = 32'(err_q) * 32'(kp_s);
  assign prod_i_s = 32'(integ_cur_s) * 32'(ki_s);

`ifdef DERIVATIVE_TERM_EN
  logic signed [W-1:0] prev_err_q [0:2];
  logic signed [W:0]   diff_raw_s;
  logic signed [W-1:0] diff_s;
  logic signed [W-1:0] kd_s;
  logic signed [W-1:0] prev_cur_s;

  assign prev_cur_s = prev_err_q[axis_q];
  assign diff_raw_s = {err_q[W-1], err_q} - {prev_cur_s[W-1], prev_cur_s};
  assign kd_s       = 16'(KD);

  signed_saturate #(.IN_W(W + 1), .LIMIT(32767)) u_diff_sat (
    .in_i  (diff_raw_s),
    .out_o (diff_s)
  );

  assign d_term_s = shift_product(32'(diff_s) * 32'(kd_s), GAIN_SHIFT);
`else
  assign d_term_s = 34'sd0;
`endif

  assign acc_d = shift_product(prod_p_s, GAIN_SHIFT) + shift_product(prod_i_s, GAIN_SHIFT) + d_term_s;

  // Sequencer and all architectural state; outputs are registered here.
  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      axis_q     <= AXIS_YAW;
      thr_q      <= ALL_ZERO_2BYTE;
      err_q      <= ALL_ZERO_2BYTE;
      acc_q      <= 34'sd0;
      throttle_q <= ALL_ZERO_2BYTE;
      active_q   <= FALSE;
      complete_q <= FALSE;
      for (int i = 0; i < 3; i++) begin
        tgt_q[i]   <= ALL_ZERO_2BYTE;
        act_q[i]   <= ALL_ZERO_2BYTE;
        integ_q[i] <= ALL_ZERO_2BYTE;
        out_q[i]   <= ALL_ZERO_2BYTE;
`ifdef DERIVATIVE_TERM_EN
        prev_err_q[i] <= ALL_ZERO_2BYTE;
`endif
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          complete_q <= FALSE;
          if (start_signal) begin
            state_q  <= ST_LATCH;
            active_q <= TRUE;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_LATCH: begin
          thr_q             <= throttle_rate_in;
          throttle_q        <= throttle_d;
          tgt_q[AXIS_YAW]   <= yaw_rate_target;
          tgt_q[AXIS_PITCH] <= pitch_rate_target;
          tgt_q[AXIS_ROLL]  <= roll_rate_target;
          act_q[AXIS_YAW]   <= yaw_rate_actual;
          act_q[AXIS_PITCH] <= pitch_rate_actual;
          act_q[AXIS_ROLL]  <= roll_rate_actual;
          axis_q            <= AXIS_YAW;
          state_q           <= ST_ERR;
        end
        ST_ERR: begin
          err_q <= err_d;
          // A disarmed craft must not wind up integrators on the ground.
          if (arm_s) begin
            integ_q[axis_q] <= integ_d;
          end else begin
            integ_q[axis_q] <= ALL_ZERO_2BYTE;
          end
          state_q <= ST_MAC;
        end
        ST_MAC: begin
          acc_q   <= acc_d;
          state_q <= ST_SAT;
        end
        ST_SAT: begin
          out_q[axis_q] <= out_d;
`ifdef DERIVATIVE_TERM_EN
          prev_err_q[axis_q] <= err_q;
`endif
          if (axis_q == AXIS_ROLL) begin
            state_q  <= ST_COMPLETE;
            active_q <= FALSE;
          end else begin
            axis_q   <= axis_q + 2'd1;
            state_q  <= ST_ERR;
          end
        end
        ST_COMPLETE: begin
          complete_q <= TRUE;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          active_q   <= FALSE;
          complete_q <= FALSE;
        end
      endcase
    end
  end

  assign throttle_out    = throttle_q;
  assign yaw_out         = out_q[AXIS_YAW];
  assign pitch_out       = out_q[AXIS_PITCH];
  assign roll_out        = out_q[AXIS_ROLL];
  assign active_signal   = active_q;
  assign complete_signal = complete_q;

endmodule
